// File: rtl/vga_fb_pkg.sv
// Shared types and default widths for the VGA framebuffer arbiter.
// The write-entry record is sized for the default widths.
package vga_fb_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/vga_fb_arbiter_fb_wr_fifo.sv
// Synchronous write-buffer FIFO with registered occupancy, full and empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_CNT);
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset: contents are only observed behind empty_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: display reads win every cycle, buffered CPU writes drain otherwise.
// Optional FB_ARB_STALL_CNT_EN adds a saturating stall_count output.
//
// state | meaning
// IDLE  | no RAM access this cycle, mem_addr held
// READ  | display read issued on mem_addr
// WRITE | FIFO head written to RAM
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef FB_ARB_STALL_CNT_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        vpipe_q;
  logic              fifo_pop, fifo_full, fifo_empty;
  entry_t            push_entry, head;

  assign push_entry = '{addr: wr_addr, data: wr_data};

  fb_wr_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(entry_t))
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (wr_valid),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d     = IDLE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fifo_pop    = 1'b0;
    if (pix_req) begin
      state_d    = READ;
      mem_addr_d = pix_addr;
    end else if (!fifo_empty) begin
      state_d     = WRITE;
      fifo_pop    = 1'b1;
      mem_addr_d  = head.addr;
      mem_wdata_d = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      vpipe_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      vpipe_q     <= {vpipe_q[0], pix_req};
    end
  end

  // Write enable is a pure decode of the registered state, so it is glitch-free.
  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pix_valid = vpipe_q[1];
  assign pix_data  = mem_rdata;
  assign wr_ready  = ~fifo_full;
  assign busy      = ~fifo_empty;

`ifdef FB_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (pix_req && !fifo_empty && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule
